// File: rtl/sram_wb_ctrl_pkg.sv
// sram_wb_ctrl_pkg: shared FSM state encoding, lane count and chip-address field positions
package sram_wb_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
    localparam int LANES = 4;
    localparam int CHIP_HI = 22;
    localparam int CHIP_LO = 21;
endpackage

// File: rtl/sram_wb_lane_sel.sv
// sram_wb_lane_sel: picks the lowest still-selected byte lane
//   mask : remaining lane-select mask
//   lane : index of the lowest set bit of mask (3 when mask is empty)
//   none : no lane left in mask
module sram_wb_lane_sel
    import sram_wb_ctrl_pkg::*;
(
    input  logic [LANES-1:0] mask,
    output logic [1:0]       lane,
    output logic             none
);
    always_comb begin
        lane = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
        none = ~|mask;
    end
endmodule

// File: rtl/sram_wb_ctrl.sv
// sram_wb_ctrl: Wishbone classic slave driving four 2Mx8 asynchronous SRAM chips one byte lane at a time
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_wb_*                       : Wishbone request (adr, sel, we, dat, cyc, stb)
//   o_wb_dat, o_wb_ack, o_wb_err : Wishbone response
//   o_sram_cs_n, o_sram_read_n, o_sram_write_n, o_sram_addr : SRAM control and address
//   o_sram_data, o_sram_data_oe, i_sram_data : split SRAM data bus
//   Define SRAM_WB_CTRL_ERR_EN to answer out-of-window addresses with o_wb_err.
module sram_wb_ctrl
    import sram_wb_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W = 23
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [3:0]  o_sram_cs_n,
    output logic        o_sram_read_n,
    output logic        o_sram_write_n,
    output logic [20:0] o_sram_addr,
    output logic [7:0]  o_sram_data,
    output logic        o_sram_data_oe,
    input  logic [7:0]  i_sram_data
);
    state_t state, state_n;
    logic [CHIP_HI:2] adr_q;
    logic [31:0] dat_q, rd_q;
    logic [LANES-1:0] rem_q, sel_in;
    logic [1:0] lane_q, lane_n;
    logic [3:0] cnt;
    logic we_q, abort_q, err_q, none, req, last, busy, out_win, skip, unused;

    sram_wb_lane_sel u_lane_sel (
        .mask(sel_in),
        .lane(lane_n),
        .none(none)
    );

    assign out_win = |i_wb_adr[31:ADDR_W];
    assign unused = ^{i_wb_adr[1:0], out_win};
`ifdef SRAM_WB_CTRL_ERR_EN
    assign skip = out_win;
    assign o_wb_err = state == DONE && err_q;
`else
    assign skip = 1'b0;
    assign o_wb_err = 1'b0;
`endif
    assign o_wb_ack = state == DONE && !err_q;
    assign req = i_wb_cyc && i_wb_stb && !o_wb_ack;
    // On acceptance the first lane comes straight from the bus; afterwards from the remaining mask.
    assign sel_in = state == IDLE ? i_wb_sel : rem_q;
    assign last = cnt == 4'(WAIT_CYCLES - 1);
    assign busy = state == SETUP || state == STROBE || state == HOLD;

    assign o_wb_dat = rd_q;
    assign o_sram_cs_n = busy ? ~(4'b0001 << adr_q[CHIP_HI:CHIP_LO]) : 4'hF;
    assign o_sram_read_n = !(state == STROBE && !we_q);
    assign o_sram_write_n = !(state == STROBE && we_q);
    assign o_sram_addr = {adr_q[CHIP_LO-1:2], lane_q};
    assign o_sram_data = busy && we_q ? dat_q[{lane_q, 3'b000} +: 8] : 8'h00;
    assign o_sram_data_oe = busy && we_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !req ? IDLE : (skip || none) ? DONE : SETUP;
            SETUP:   state_n = STROBE;
            STROBE:  state_n = last ? HOLD : STROBE;
            // A dropped cycle lets the current lane finish, then abandons the rest without ack.
            HOLD:    state_n = (abort_q || !i_wb_cyc) ? IDLE : none ? DONE : SETUP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            adr_q <= '0;
            we_q <= 1'b0;
            dat_q <= '0;
            rd_q <= '0;
            rem_q <= '0;
            lane_q <= '0;
            cnt <= '0;
            abort_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                adr_q <= i_wb_adr[CHIP_HI:2];
                we_q <= i_wb_we;
                dat_q <= i_wb_dat;
                rd_q <= '0;
                abort_q <= 1'b0;
                err_q <= skip;
            end else if (busy && !i_wb_cyc) begin
                abort_q <= 1'b1;
            end
            if (state_n == SETUP) begin
                lane_q <= lane_n;
                rem_q <= sel_in & ~(LANES'(1) << lane_n);
            end
            cnt <= state == STROBE ? cnt + 4'd1 : 4'd0;
            if (state == STROBE && last && !we_q)
                rd_q[{lane_q, 3'b000} +: 8] <= i_sram_data;
        end
    end
endmodule

// File: tb/tb_sram_wb_ctrl.sv
// tb_sram_wb_ctrl: self-checking bench for sram_wb_ctrl with an SRAM device model and a byte-memory reference
module tb_sram_wb_ctrl;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [3:0] wb_sel = '0;
    logic wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [31:0] o_wb_dat;
    logic o_wb_ack, o_wb_err;
    logic [3:0] o_sram_cs_n;
    logic o_sram_read_n, o_sram_write_n, o_sram_data_oe;
    logic [20:0] o_sram_addr;
    logic [7:0] o_sram_data;
    logic [7:0] i_sram_data = 8'h5A;

    int errors = 0, checks = 0;
    int rd_low = 0, wr_low = 0, cs_act = 0, ack_cnt = 0, viol = 0;
    logic [3:0] lanes_seen = '0;
    logic mon_en = 1'b0;
    logic [20:0] prev_addr;
    logic [3:0] prev_cs;
    logic prev_oe;

    bit [7:0] dev_mem [int];
    bit [7:0] ref_mem [int];

    always #5 clk = ~clk;

    sram_wb_ctrl #(.WAIT_CYCLES(W), .ADDR_W(23)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_wb_adr(wb_adr),
        .i_wb_sel(wb_sel),
        .i_wb_we(wb_we),
        .i_wb_dat(wb_dat),
        .i_wb_cyc(wb_cyc),
        .i_wb_stb(wb_stb),
        .o_wb_dat(o_wb_dat),
        .o_wb_ack(o_wb_ack),
        .o_wb_err(o_wb_err),
        .o_sram_cs_n(o_sram_cs_n),
        .o_sram_read_n(o_sram_read_n),
        .o_sram_write_n(o_sram_write_n),
        .o_sram_addr(o_sram_addr),
        .o_sram_data(o_sram_data),
        .o_sram_data_oe(o_sram_data_oe),
        .i_sram_data(i_sram_data)
    );

    function automatic int chip_of(logic [3:0] cs);
        case (cs)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int dev_key();
        return chip_of(o_sram_cs_n) * (1 << 21) + int'(o_sram_addr);
    endfunction

    function automatic logic [7:0] dev_rd(int k);
        return dev_mem.exists(k) ? dev_mem[k] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(int k);
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    function automatic int lane_key(logic [31:0] adr, int lane);
        return int'(adr[22:2]) * 4 + lane;
    endfunction

    // SRAM device: writes land on every write-strobe edge, read data is presented while read_n is low.
    always @(posedge clk)
        if (mon_en && !o_sram_write_n && chip_of(o_sram_cs_n) >= 0)
            dev_mem[dev_key()] = o_sram_data;

    always @(negedge clk)
        i_sram_data <= (!o_sram_read_n && chip_of(o_sram_cs_n) >= 0) ? dev_rd(dev_key()) : 8'h5A;

    // Bus monitor: strobe counts, lanes touched, acks, and strobe/address/oe stability.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!o_sram_read_n) rd_low++;
            if (!o_sram_write_n) wr_low++;
            if (o_sram_cs_n != 4'hF) cs_act++;
            if (o_wb_ack) ack_cnt++;
            if (!o_sram_read_n || !o_sram_write_n) begin
                lanes_seen[o_sram_addr[1:0]] = 1'b1;
                if (o_sram_addr != prev_addr || o_sram_cs_n != prev_cs || o_sram_data_oe != prev_oe) viol++;
                if (chip_of(o_sram_cs_n) < 0) viol++;
            end
            if (!o_sram_read_n && o_sram_data_oe) viol++;
        end
        prev_addr = o_sram_addr;
        prev_cs = o_sram_cs_n;
        prev_oe = o_sram_data_oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                        output logic [31:0] rdata, output int lat, output logic got_err);
        @(negedge clk);
        rd_low = 0;
        wr_low = 0;
        cs_act = 0;
        wb_we = we;
        wb_adr = adr;
        wb_sel = sel;
        wb_dat = dat;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        lat = 0;
        rdata = '0;
        got_err = 1'b0;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(negedge clk);
            if (o_wb_ack || o_wb_err) begin
                lat = n;
                rdata = o_wb_dat;
                got_err = o_wb_err;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got no response for adr %h expected ack", adr);
        end
    endtask

    // Reference model: byte-addressed memory updated from the selected lanes of each write.
    task automatic ref_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        for (int l = 0; l < 4; l++)
            if (sel[l]) ref_mem[lane_key(adr, l)] = dat[8*l +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] adr, input logic [3:0] sel);
        logic [31:0] r = '0;
        for (int l = 0; l < 4; l++)
            if (sel[l]) r[8*l +: 8] = ref_rd(lane_key(adr, l));
        return r;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_dat;
        int          exp_lat;
        int          exp_strb;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] rdata, adr;
        logic [3:0] sel;
        logic we, got_err;
        int lat, k;
        bit found;

        vecs[0] = '{1'b1, 32'h0000_1000, 4'hF,    32'hA1B2_C3D4, 32'h0000_0000, 17, 8};
        vecs[1] = '{1'b0, 32'h0000_1000, 4'hF,    32'h0,         32'hA1B2_C3D4, 17, 8};
        vecs[2] = '{1'b1, 32'h0060_0004, 4'b0100, 32'h00EE_0000, 32'h0000_0000, 5,  2};
        vecs[3] = '{1'b0, 32'h0060_0004, 4'hF,    32'h0,         32'h00EE_0000, 17, 8};
        vecs[4] = '{1'b0, 32'h0000_1000, 4'h0,    32'h0,         32'h0000_0000, 1,  0};
        vecs[5] = '{1'b0, 32'h0000_1000, 4'b1001, 32'h0,         32'hA100_00D4, 9,  4};
        vecs[6] = '{1'b1, 32'h0020_0010, 4'b0011, 32'h1234_5678, 32'h0000_0000, 9,  4};
        vecs[7] = '{1'b0, 32'h0020_0010, 4'b0010, 32'h0,         32'h0000_5600, 5,  2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", {28'h0, o_sram_cs_n}, 32'hF);
        check("rst_strobes", {30'h0, o_sram_read_n, o_sram_write_n}, 32'h3);
        check("rst_addr", {11'h0, o_sram_addr}, 32'h0);
        check("rst_data_oe", {23'h0, o_sram_data_oe, o_sram_data}, 32'h0);
        check("rst_ack_err", {30'h0, o_wb_ack, o_wb_err}, 32'h0);
        check("rst_wb_dat", o_wb_dat, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rdata, lat, got_err);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_strobe", i), vecs[i].we ? wr_low : rd_low, vecs[i].exp_strb);
            check($sformatf("vec%0d_other_strobe", i), vecs[i].we ? rd_low : wr_low, 0);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_dat);
            else ref_write(vecs[i].adr, vecs[i].sel, vecs[i].dat);
        end
        check("mem_1000", dev_rd(32'h1000), 8'hD4);
        check("mem_1001", dev_rd(32'h1001), 8'hC3);
        check("mem_1002", dev_rd(32'h1002), 8'hB2);
        check("mem_1003", dev_rd(32'h1003), 8'hA1);
        check("mem_chip3_6", dev_rd(3 * (1 << 21) + 6), 8'hEE);
        check("mem_chip3_7", dev_rd(3 * (1 << 21) + 7), 8'h00);

        // Reset during the strobe of lane 2 aborts the access on that edge.
        @(negedge clk);
        ack_cnt = 0;
        wb_we = 1'b0;
        wb_adr = 32'h0000_1000;
        wb_sel = 4'hF;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = !o_sram_read_n && o_sram_addr[1:0] == 2'd2;
        end
        check("rst_mid_reached", {31'h0, found}, 32'h1);
        rst = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_strobes", {30'h0, o_sram_read_n, o_sram_write_n}, 32'h3);
        check("rst_mid_cs_n", {28'h0, o_sram_cs_n}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_no_ack", ack_cnt, 0);
        xfer(1'b0, 32'h0000_1000, 4'hF, 32'h0, rdata, lat, got_err);
        check("after_rst_rdata", rdata, 32'hA1B2_C3D4);
        check("after_rst_lat", lat, 17);

        // Dropping cyc during lane 1 finishes that lane and returns to idle without ack.
        @(negedge clk);
        ack_cnt = 0;
        lanes_seen = '0;
        wb_we = 1'b0;
        wb_adr = 32'h0000_1000;
        wb_sel = 4'hF;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            found = !o_sram_read_n && o_sram_addr[1:0] == 2'd1;
        end
        check("abort_reached", {31'h0, found}, 32'h1);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_ack", ack_cnt, 0);
        check("abort_lanes", {28'h0, lanes_seen}, 32'h3);
        check("abort_cs_idle", {28'h0, o_sram_cs_n}, 32'hF);

        // Out-of-window address: error response or aliasing onto chip 0.
        xfer(1'b1, 32'h0100_0000, 4'b0001, 32'hCAFE_F00D, rdata, lat, got_err);
`ifdef SRAM_WB_CTRL_ERR_EN
        check("oow_wr_err", {31'h0, got_err}, 32'h1);
        check("oow_wr_lat", lat, 1);
        check("oow_wr_cs", cs_act, 0);
`else
        check("oow_wr_err", {31'h0, got_err}, 32'h0);
        check("oow_wr_lat", lat, 5);
        check("oow_wr_mem0", dev_rd(0), 8'h0D);
        ref_write(32'h0100_0000, 4'b0001, 32'hCAFE_F00D);
`endif
        xfer(1'b0, 32'h0100_0000, 4'hF, 32'h0, rdata, lat, got_err);
`ifdef SRAM_WB_CTRL_ERR_EN
        check("oow_rd_err", {31'h0, got_err}, 32'h1);
        check("oow_rd_cs", cs_act, 0);
`else
        check("oow_rd_rdata", rdata, 32'h0000_000D);
        check("oow_rd_lat", lat, 17);
`endif

        // Randomised traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom);
            sel = 4'($urandom);
            adr = $urandom & 32'h0060_000C;
`ifndef SRAM_WB_CTRL_ERR_EN
            adr = adr | ($urandom & 32'hFF80_0003);
`endif
            xfer(we, adr, sel, $urandom, rdata, lat, got_err);
            k = $countones(sel);
            check($sformatf("rnd%0d_lat", i), lat, 1 + k * (W + 2));
            check($sformatf("rnd%0d_strobe", i), we ? wr_low : rd_low, k * W);
            if (we) ref_write(adr, sel, wb_dat);
            else check($sformatf("rnd%0d_rdata", i), rdata, ref_read(adr, sel));
        end

        check("protocol_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_wb_ctrl.md
SRAM_WB_CTRL -- requirements
Module: sram_wb_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the strobe-low width in i_clk cycles (legal range 1..15).
REQ-002 The block SHALL have parameter ADDR_W, default 23, giving the byte-address width (4 chips x 2M x 8).
REQ-003 Port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports i_wb_adr (32), i_wb_sel (4), i_wb_we (1), i_wb_dat (32), i_wb_cyc (1), i_wb_stb (1), all inputs: the Wishbone classic slave request.
REQ-006 Ports o_wb_dat (32), o_wb_ack (1), o_wb_err (1), all outputs: the Wishbone slave response.
REQ-007 Port o_sram_cs_n, output, 4 bits: active-low chip selects.
REQ-008 Ports o_sram_read_n and o_sram_write_n, outputs, 1 bit each: active-low strobes.
REQ-009 Port o_sram_addr, output, 21 bits: chip-internal byte address.
REQ-010 Ports o_sram_data (8, output), o_sram_data_oe (1, output) and i_sram_data (8, input): the split data bus; the tri-state is built at top level.

Function
REQ-011 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD and DONE.
REQ-012 In IDLE, i_wb_cyc&i_wb_stb with o_wb_ack low SHALL latch adr, sel, we and dat, then go to SETUP for the lowest lane whose sel bit is set.
REQ-013 A request with sel=4'h0 SHALL go straight to DONE.
REQ-014 Lane n SHALL use byte address {i_wb_adr[22:2], n} (little-endian).
REQ-015 The chip select SHALL be o_sram_cs_n[addr[22:21]] low and the others high; o_sram_addr SHALL be addr[20:0].
REQ-016 SETUP SHALL last 1 cycle: address and CS valid, both strobes high, and for writes o_sram_data_oe=1 with o_sram_data driven.
REQ-017 STROBE SHALL hold read_n or write_n (per we) low for exactly WAIT_CYCLES cycles.
REQ-018 For reads, i_sram_data SHALL be captured into the lane's byte on the last STROBE cycle.
REQ-019 HOLD SHALL last 1 cycle: strobes high, address, CS, data and oe unchanged.
REQ-020 After HOLD, the FSM SHALL go to SETUP for the next higher selected lane, or to DONE if no selected lane remains.
REQ-021 Unselected lanes SHALL cost 0 cycles.
REQ-022 DONE SHALL pulse o_wb_ack high for exactly 1 cycle, with CS all high and oe=0, then return to IDLE.
REQ-023 Latency from stb sampled to ack SHALL be 1 + k*(WAIT_CYCLES+2) cycles, where k is the number of set sel bits.
REQ-024 On a read, o_wb_dat SHALL be valid during ack; unselected lanes SHALL read as 8'h00.
REQ-025 The strobes SHALL never be low in the same cycle as an address, CS or oe change.
REQ-026 A write never drives o_sram_data_oe while read_n is low.
REQ-027 If i_wb_cyc drops mid-transfer, the current lane SHALL finish through HOLD, then the FSM SHALL go to IDLE without ack.
REQ-028 A new request is accepted no earlier than the cycle after DONE (no back-to-back ack).

Reset
REQ-029 While i_rst is high at a clock edge, the block SHALL force: state IDLE, o_sram_cs_n=4'hF, read_n=1, write_n=1, o_sram_addr=0, o_sram_data=0, oe=0, o_wb_ack=0, o_wb_err=0, o_wb_dat=0.
REQ-030 Reset asserted mid-access SHALL abort it on that edge with no ack and no further strobe.

Configuration
REQ-031 Macro SRAM_WB_CTRL_ERR_EN SHALL select out-of-window error handling.
REQ-032 With SRAM_WB_CTRL_ERR_EN defined, a request with i_wb_adr[31:ADDR_W]!=0 SHALL skip all SRAM cycles and pulse o_wb_err (not ack) for 1 cycle, 1 cycle after acceptance.
REQ-033 Without SRAM_WB_CTRL_ERR_EN, upper address bits SHALL be ignored (aliasing) and o_wb_err SHALL be tied 0.

Structure
REQ-034 A shared package SHALL hold the state encoding typedef, the lane-count constant (4) and the chip-address field positions (22:21).
REQ-035 One sub-module, sram_wb_lane_sel, SHALL compute the next selected lane from the remaining sel mask (priority encoder plus a "none left" flag).

Verification
REQ-036 Reset, then a write to adr 0x0000_1000, sel F, dat 0xA1B2C3D4, WAIT_CYCLES=2 -> SRAM chip 0 bytes at 0x1000..0x1003 = D4,C3,B2,A1; ack 17 cycles after stb.
REQ-037 Read of adr 0x0000_1000, sel F -> o_wb_dat=0xA1B2C3D4 at ack; read_n low exactly 2 cycles per byte.
REQ-038 Write to adr 0x0060_0004, sel 4'b0100, dat 0x00EE0000 -> only chip 3 (cs_n=4'b0111) address 0x000006 written with EE; ack 5 cycles after stb.
REQ-039 sel=0 request -> ack 1 cycle later, no strobe; then a read with sel 4'b1001 -> lanes 1 and 2 return 0x00.
REQ-040 i_rst pulsed during the STROBE of lane 2 -> strobes high and cs_n=4'hF on the next edge, no ack; the following request completes normally.
REQ-041 SRAM_WB_CTRL_ERR_EN defined, access to 0x0100_0000 -> err pulse, no CS activity; macro undefined -> same access aliases to chip 0 address 0 and acks.
